// File: rtl/program_serializer_pkg.sv
// program_serializer_pkg
// Constants and types shared between the serializer and the one-bit
// processor it feeds: instruction width, program-counter width,
// instruction-memory depth and the serializer state encoding.
package program_serializer_pkg;

  localparam int INSTR_W   = 13;
  localparam int CNT_W     = 10;
  localparam int BIT_CNT_W = 4;

  localparam logic [CNT_W-1:0]     MAX_INSTR = CNT_W'(1000);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(INSTR_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SHIFT
  } state_t;

endpackage

// File: rtl/program_serializer_if.sv
// program_serializer_if
// Instruction-word stream feeding the serializer.
//   instr_data  : instruction word, bit 0 is the control bit
//   instr_valid : source has a word on instr_data
//   instr_ready : serializer takes the word this cycle
// master = word source, slave = serializer.
interface program_serializer_if;
  import program_serializer_pkg::*;

  logic [INSTR_W-1:0] instr_data;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr_data, output instr_valid, input instr_ready);
  modport slave  (input instr_data, input instr_valid, output instr_ready);

endinterface

// File: rtl/program_serializer_instr_word_buf.sv
// program_serializer_instr_word_buf
// One-entry holding register for the next instruction word.
//   clk, reset : clock, synchronous active-high reset (empties the entry)
//   push, push_data : write a word (caller guarantees room or a same-cycle pop)
//   pop        : consume the held word
//   full, data : entry occupied / held word
module program_serializer_instr_word_buf
  import program_serializer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic [INSTR_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      // push alone or push+pop: entry ends up holding the new word
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/program_serializer.sv
// program_serializer
// Turns a stream of instruction words into the processor's serial load
// protocol: load enable high, bits LSB-first, one per clock, words back to
// back. Dropping the enable releases the processor to run from address 0.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request a load (IDLE only), num_instr = word count
//   instr       : instruction word stream (slave side)
//   ser_en      : processor load enable
//   ser_bit     : processor serial data bit
//   busy        : not IDLE
//   done / err  : one-cycle completion / rejection-or-underrun pulses
//
// state | meaning
// IDLE  | no load in progress, waiting for start
// PRIME | count accepted, waiting for the first word
// SHIFT | shifting a word out, prefetching the next one
module program_serializer
  import program_serializer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_instr,
  program_serializer_if.slave  instr,
  output logic                 ser_en,
  output logic                 ser_bit,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t                 state;
  logic [INSTR_W-1:0]     shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]       remaining;   // words not yet fully shifted, incl. current
  logic                   buf_full;
  logic [INSTR_W-1:0]     buf_data;
  logic                   handshake;
  logic                   push;
  logic                   pop;
  logic                   last_bit;

  // Prefetch only while a word beyond the one shifting is still owed;
  // this also keeps the stream from ever giving up more than num_instr words.
  assign instr.instr_ready = (state == PRIME) ||
                             ((state == SHIFT) && !buf_full && (remaining > ONE));
  assign busy      = (state != IDLE);
  assign handshake = instr.instr_valid && instr.instr_ready;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign push      = (state == SHIFT) && handshake;
  assign pop       = (state == SHIFT) && last_bit && (remaining != ONE) && buf_full;

  program_serializer_instr_word_buf u_word_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (instr.instr_data),
    .pop       (pop),
    .full      (buf_full),
    .data      (buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      remaining <= '0;
      ser_en    <= 1'b0;
      ser_bit   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ((num_instr == '0) || (num_instr > MAX_INSTR)) begin
              err <= 1'b1;
            end else begin
              remaining <= num_instr;
              state     <= PRIME;
            end
          end
        end
        PRIME: begin
          if (handshake) begin
            shreg   <= instr.instr_data;
            ser_bit <= instr.instr_data[0];
            ser_en  <= 1'b1;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shreg   <= shreg >> 1;
            ser_bit <= shreg[1];
            bit_cnt <= bit_cnt + 1'b1;
          end else if (remaining == ONE) begin
            state     <= IDLE;
            ser_en    <= 1'b0;
            ser_bit   <= 1'b0;
            bit_cnt   <= '0;
            remaining <= '0;
            done      <= 1'b1;
          end else if (buf_full) begin
            // seamless hand-over keeps ser_en high across the word boundary
            shreg     <= buf_data;
            ser_bit   <= buf_data[0];
            bit_cnt   <= '0;
            remaining <= remaining - ONE;
          end else begin
            // underrun: the processor only restarts on a fresh enable edge
            state     <= IDLE;
            ser_en    <= 1'b0;
            ser_bit   <= 1'b0;
            bit_cnt   <= '0;
            remaining <= '0;
            err       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_serializer.sv
// tb_program_serializer
// Directed bench for program_serializer with a small processor load model
// that rebuilds instruction memory from ser_en/ser_bit.
module tb_program_serializer;
  import program_serializer_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_instr = '0;
  logic             ser_en, ser_bit, busy, done, err;

  program_serializer_if bus ();

  program_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_instr (num_instr),
    .instr     (bus),
    .ser_en    (ser_en),
    .ser_bit   (ser_bit),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [INSTR_W-1:0] words [0:3];

  // processor load model and event counters, sampled on the falling edge
  int en_cycles = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0, ready_cnt = 0;
  int rise_cnt = 0, fall_done_cnt = 0, fall_err_cnt = 0;
  int run_len = 0, last_run = 0, low_len = 0, last_gap = 0;
  int ld_len = 0, p_addr = 0, p_bits = 0;
  logic prev_en = 1'b0;
  logic [INSTR_W-1:0] p_word = '0;
  logic [INSTR_W-1:0] mem [0:15];
  logic ld_bits [0:63];

  always @(negedge clk) begin
    if (ser_en && !prev_en) begin
      rise_cnt++;
      last_gap = low_len;
      p_addr = 0; p_bits = 0; ld_len = 0; run_len = 0;
    end
    if (ser_en) begin
      en_cycles++; run_len++; low_len = 0;
      p_word = {ser_bit, p_word[INSTR_W-1:1]};
      p_bits++;
      if (p_bits == INSTR_W) begin
        mem[p_addr[3:0]] = p_word;
        p_addr++;
        p_bits = 0;
      end
      if (ld_len < 64) ld_bits[ld_len[5:0]] = ser_bit;
      ld_len++;
    end else begin
      low_len++;
    end
    if (!ser_en && prev_en) begin
      last_run = run_len;
      if (done) fall_done_cnt++;
      if (err) fall_err_cnt++;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (bus.instr_ready) ready_cnt++;
    if (bus.instr_valid && bus.instr_ready) acc_cnt++;
    prev_en = ser_en;
  end

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_instr = n[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // present words[0..n-1] in order, holding each until it is taken
  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int t;
      if (i == 0) repeat (gap) begin @(posedge clk); #1; end
      bus.instr_data  = words[i];
      bus.instr_valid = 1'b1;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (bus.instr_ready) break;
        t++;
        if (t > 200) begin
          checks++; errors++;
          $display("FAIL feed_timeout word=%0d got=no_ready exp=ready", i);
          bus.instr_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int t = 0;
    while (1) begin
      @(negedge clk);
      if (done || err) break;
      t++;
      if (t > budget) begin
        checks++; errors++;
        $display("FAIL wait_end_timeout got=no_pulse exp=done_or_err");
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ser_en !== 1'b0) begin errors++; $display("FAIL reset_ser_en got=%0b exp=0", ser_en); end
    checks++; if (ser_bit !== 1'b0) begin errors++; $display("FAIL reset_ser_bit got=%0b exp=0", ser_bit); end
    checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", bus.instr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
  endtask

  task automatic test_single();
    int s_en = en_cycles, s_rise = rise_cnt, s_fd = fall_done_cnt, s_done = done_cnt, s_err = err_cnt;
    logic [0:12] exp_seq;
    exp_seq = 13'b1101101001011;
    words[0] = 13'h1A5B;
    do_start(1);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%0b exp=1", busy); end
    feed(1, 3);
    @(negedge clk);
    checks++; if ({ser_en, ser_bit} !== 2'b11) begin errors++; $display("FAIL single_first_bit got=%b exp=11", {ser_en, ser_bit}); end
    wait_end(100);
    checks++; if ({done, err, ser_en} !== 3'b100) begin errors++; $display("FAIL single_end got=%b exp=100", {done, err, ser_en}); end
    repeat (2) @(posedge clk); #1;
    checks++; if (en_cycles - s_en !== 13) begin errors++; $display("FAIL single_en_cycles got=%0d exp=13", en_cycles - s_en); end
    checks++; if (rise_cnt - s_rise !== 1) begin errors++; $display("FAIL single_rises got=%0d exp=1", rise_cnt - s_rise); end
    checks++; if (fall_done_cnt - s_fd !== 1) begin errors++; $display("FAIL single_done_on_fall got=%0d exp=1", fall_done_cnt - s_fd); end
    checks++; if ((done_cnt - s_done !== 1) || (err_cnt - s_err !== 0)) begin errors++; $display("FAIL single_pulses got=%0d/%0d exp=1/0", done_cnt - s_done, err_cnt - s_err); end
    for (int i = 0; i < 13; i++) begin
      checks++; if (ld_bits[i] !== exp_seq[i]) begin errors++; $display("FAIL single_bit%0d got=%0b exp=%0b", i, ld_bits[i], exp_seq[i]); end
    end
    checks++; if (mem[0] !== 13'h1A5B) begin errors++; $display("FAIL single_mem0 got=%h exp=1a5b", mem[0]); end
  endtask

  task automatic test_multi();
    int s_en = en_cycles, s_rise = rise_cnt, s_acc = acc_cnt, s_done = done_cnt;
    words[0] = 13'h1FFF; words[1] = 13'h0000; words[2] = 13'h0AAA;
    do_start(3);
    feed(3, 0);
    wait_end(200);
    bus.instr_data = 13'h1555; bus.instr_valid = 1'b1;
    repeat (5) @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    checks++; if (en_cycles - s_en !== 39) begin errors++; $display("FAIL multi_en_cycles got=%0d exp=39", en_cycles - s_en); end
    checks++; if ((rise_cnt - s_rise !== 1) || (last_run !== 39)) begin errors++; $display("FAIL multi_contiguous got=%0d/%0d exp=1/39", rise_cnt - s_rise, last_run); end
    checks++; if (acc_cnt - s_acc !== 3) begin errors++; $display("FAIL multi_accepts got=%0d exp=3", acc_cnt - s_acc); end
    checks++; if (done_cnt - s_done !== 1) begin errors++; $display("FAIL multi_done got=%0d exp=1", done_cnt - s_done); end
    checks++; if ({mem[0], mem[1], mem[2]} !== {13'h1FFF, 13'h0000, 13'h0AAA}) begin errors++; $display("FAIL multi_mem got=%h %h %h exp=1fff 0000 0aaa", mem[0], mem[1], mem[2]); end
  endtask

  task automatic test_underrun();
    int s_en = en_cycles, s_acc = acc_cnt, s_done = done_cnt, s_fe = fall_err_cnt;
    words[0] = 13'h0F0F;
    do_start(2);
    feed(1, 0);
    wait_end(100);
    checks++; if ({done, err, ser_en} !== 3'b010) begin errors++; $display("FAIL underrun_end got=%b exp=010", {done, err, ser_en}); end
    bus.instr_data = 13'h00F0; bus.instr_valid = 1'b1;
    repeat (5) @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    checks++; if ((en_cycles - s_en !== 13) || (last_run !== 13)) begin errors++; $display("FAIL underrun_en got=%0d/%0d exp=13/13", en_cycles - s_en, last_run); end
    checks++; if (fall_err_cnt - s_fe !== 1) begin errors++; $display("FAIL underrun_err_on_fall got=%0d exp=1", fall_err_cnt - s_fe); end
    checks++; if ((done_cnt - s_done !== 0) || (acc_cnt - s_acc !== 1)) begin errors++; $display("FAIL underrun_done_acc got=%0d/%0d exp=0/1", done_cnt - s_done, acc_cnt - s_acc); end
  endtask

  task automatic test_bad_count();
    int bad [0:1];
    bad[0] = 0; bad[1] = 1001;
    for (int k = 0; k < 2; k++) begin
      int s_rise = rise_cnt, s_rdy = ready_cnt, s_err = err_cnt, s_done = done_cnt;
      bus.instr_data = 13'h1111; bus.instr_valid = 1'b1;
      do_start(bad[k]);
      @(negedge clk);
      checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL bad%0d_pulse got=%b exp=10", bad[k], {err, busy}); end
      repeat (3) @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      checks++; if ((rise_cnt - s_rise !== 0) || (ready_cnt - s_rdy !== 0)) begin errors++; $display("FAIL bad%0d_quiet got=%0d/%0d exp=0/0", bad[k], rise_cnt - s_rise, ready_cnt - s_rdy); end
      checks++; if ((err_cnt - s_err !== 1) || (done_cnt - s_done !== 0)) begin errors++; $display("FAIL bad%0d_counts got=%0d/%0d exp=1/0", bad[k], err_cnt - s_err, done_cnt - s_done); end
    end
    do_start(1000);
    @(negedge clk);
    checks++; if ({busy, err, bus.instr_ready} !== 3'b101) begin errors++; $display("FAIL max_count_accept got=%b exp=101", {busy, err, bus.instr_ready}); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s_rise = rise_cnt, s_done = done_cnt, s_err = err_cnt, s_acc = acc_cnt, t = 0;
    words[0] = 13'h0101; words[1] = 13'h1234; words[2] = 13'h0555; words[3] = 13'h1F00;
    do_start(4);
    feed(3, 0);
    while (!((rise_cnt > s_rise) && (ld_len == 20))) begin
      @(negedge clk); #1;
      t++;
      if (t > 200) begin checks++; errors++; $display("FAIL reset_mid_timeout got=%0d exp=20", ld_len); break; end
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if ({ser_en, ser_bit, bus.instr_ready, busy, done, err} !== 6'b0) begin errors++; $display("FAIL reset_mid_outputs got=%b exp=000000", {ser_en, ser_bit, bus.instr_ready, busy, done, err}); end
    repeat (3) @(posedge clk); #1;
    checks++; if ((done_cnt - s_done !== 0) || (err_cnt - s_err !== 0) || (last_run !== 20)) begin errors++; $display("FAIL reset_mid_no_pulse got=%0d/%0d/%0d exp=0/0/20", done_cnt - s_done, err_cnt - s_err, last_run); end
    checks++; if (acc_cnt - s_acc !== 3) begin errors++; $display("FAIL reset_mid_accepts got=%0d exp=3", acc_cnt - s_acc); end
    words[0] = 13'h0123;
    do_start(1);
    feed(1, 0);
    wait_end(100);
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL reset_mid_reload_end got=%b exp=10", {done, err}); end
    repeat (2) @(posedge clk); #1;
    checks++; if ((mem[0] !== 13'h0123) || (last_run !== 13)) begin errors++; $display("FAIL reset_mid_reload got=%h/%0d exp=0123/13", mem[0], last_run); end
  endtask

  task automatic test_back_to_back();
    int s_rise = rise_cnt, s_done = done_cnt;
    words[0] = 13'h1234;
    do_start(1);
    feed(1, 0);
    wait_end(100);
    words[0] = 13'h0C3D;
    do_start(1);
    feed(1, 0);
    wait_end(100);
    repeat (2) @(posedge clk); #1;
    checks++; if ((rise_cnt - s_rise !== 2) || (done_cnt - s_done !== 2)) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", rise_cnt - s_rise, done_cnt - s_done); end
    checks++; if (last_gap < 1) begin errors++; $display("FAIL b2b_low_gap got=%0d exp=>=1", last_gap); end
    checks++; if ((mem[0] !== 13'h0C3D) || (p_addr !== 1)) begin errors++; $display("FAIL b2b_reload got=%h/%0d exp=0c3d/1", mem[0], p_addr); end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    test_reset();
    test_single();
    test_multi();
    test_underrun();
    test_bad_count();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_serializer.md
# program_serializer

Upstream feeder for the one-bit processor's instruction memory. Accepts 13-bit instruction words over a valid/ready handshake and converts them into the processor's serial load protocol: program-load enable held high, instruction bits LSB-first on the serial data line, one bit per clock, words back-to-back. It ends the load by dropping the enable, which releases the processor to execute from instruction 0.

## Interface
- INSTR_W, 13, bits per instruction word
- CNT_W, 10, width of instruction count; equals processor program-counter width
- MAX_INSTR, 1000, maximum words per program; equals processor instruction-memory depth
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to begin a load; sampled only in IDLE
- num_instr  in  CNT_W  words to load; captured on accepted start
- instr_data  in  INSTR_W  instruction word; bit 0 is the control bit
- instr_valid  in  1  instr_data valid
- instr_ready  out  1  serializer can accept a word this cycle
- ser_en  out  1  drives processor load enable
- ser_bit  out  1  drives processor input bit 0
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse: load completed
- err  out  1  one-cycle pulse: load rejected or aborted

## Operation
- States: IDLE, PRIME, SHIFT.
- IDLE: ser_en=0, ser_bit=0, instr_ready=0. On start: if num_instr==0 or num_instr>MAX_INSTR, pulse err next cycle and stay in IDLE. Otherwise capture count into remaining and go to PRIME.
- PRIME: instr_ready=1, ser_en=0. On handshake, load the word into the shift register and go to SHIFT. PRIME waits indefinitely.
- SHIFT: ser_en=1, ser_bit=shreg[0]. Shift right each cycle and increment bit_cnt from 0 to INSTR_W-1.
- One-entry prefetch buffer: instr_ready=1 in SHIFT while the buffer is empty and remaining>1 (counting the word currently shifting).
- At bit_cnt==INSTR_W-1:
  - remaining==1: go to IDLE and pulse done.
  - Buffer full: move the buffer into the shift register, set bit_cnt=0, decrement remaining. The buffer may be refilled on the same cycle.
  - Buffer empty (underrun): go to IDLE and pulse err. ser_en falls the next cycle.
- Underrun recovery: the processor's load counters reset on the rising edge of its load enable, so software restarts the whole load with a new start. Partial memory contents are overwritten.
- Words beyond num_instr are never accepted.
- start outside IDLE is ignored.

## Timing
- Reset: state IDLE; ser_en=0, ser_bit=0, instr_ready=0, busy=0, done=0, err=0. Buffer is cleared and counters are zeroed. Reset mid-SHIFT drops ser_en on the next cycle with no done or err pulse.
- Handshake in PRIME on cycle T: ser_en=1 and ser_bit=word[0] from T+1 through T+13.
- ser_en stays high for exactly 13·N contiguous cycles; there are no gaps between words.
- done (or underrun err) is asserted in the first cycle with ser_en=0 after the final bit.
- ser_en is low for at least one cycle between loads, which guarantees a fresh rising edge.
- All outputs are registered. instr_ready is a function of registered state only.
- Latency from start to first ser_en is at least 2 cycles: start→PRIME, then handshake.

## Structure
- Shared package (shared with the processor): INSTR_W, CNT_W and MAX_INSTR constants; the state enum {IDLE, PRIME, SHIFT}.
- One natural sub-module: instr_word_buf, a one-entry valid/ready holding register with push, pop and simultaneous push+pop.
- The top level contains the FSM, shift register, bit_cnt (4 bits) and remaining (CNT_W bits).

## Test plan
- N=1, word 13'h1A5B presented immediately → ser_en high for 13 cycles, ser_bit sequence 1,1,0,1,1,0,1,0,0,1,0,1,1; done pulse on the cycle ser_en falls.
- N=3, words always valid → 39 contiguous ser_en cycles; instr_ready accepts exactly 3 words; done once.
- N=2, second word withheld until after bit 12 of the first → err pulse; ser_en falls the cycle after the last bit of word 1; no done.
- num_instr=0 and num_instr=1001 → err pulse; ser_en never rises; instr_ready stays 0.
- reset asserted at bit 6 of word 2 of 4 → all outputs are reset values next cycle; a new start with N=1 then loads normally.
- Back-to-back: start issued the cycle after done → ser_en is low for at least 1 cycle between loads; the processor model reloads from address 0.
